// File: rtl/imem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// imem_arbiter_pkg
//   Shared types and defaults for the instruction-memory arbiter.
//
//   Contents:
//     IMEM_DATA_W      default memory word width (32)
//     IMEM_ADDR_W      default word-index address width (10 -> 1024 words)
//     IMEM_STARVE_MAX  default number of denied loader cycles before the
//                      loader wins a contested cycle
//     owner_e          owner / arbitration state encodings
//     starve_cnt_w()   width needed to hold a count of 0..max_cnt
// -----------------------------------------------------------------------------
package imem_arbiter_pkg;

    localparam int unsigned IMEM_DATA_W     = 32;
    localparam int unsigned IMEM_ADDR_W     = 10;
    localparam int unsigned IMEM_STARVE_MAX = 4;

    // NONE/FETCH/LOAD_RD record who owns the read data returning next cycle.
    // LOCKED is the arbitration state used when the loader holds the memory
    // exclusively (only present when the lock feature is compiled in).
    typedef enum logic [1:0] {
        OWN_NONE    = 2'd0,
        OWN_FETCH   = 2'd1,
        OWN_LOAD_RD = 2'd2,
        OWN_LOCKED  = 2'd3
    } owner_e;

    // Minimum number of bits able to represent max_cnt (at least 1).
    function automatic int unsigned starve_cnt_w(input int unsigned max_cnt);
        int unsigned w;
        w = 1;
        while ((max_cnt >> w) != 0) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/imem_arb_starve_ctr.sv
// -----------------------------------------------------------------------------
// imem_arb_starve_ctr
//   Saturating starvation counter for the loader side of imem_arbiter.
//   Counts consecutive cycles in which the loader requests but is not
//   granted; clears whenever the loader is granted or stops requesting.
//
//   Parameters:
//     STARVE_MAX  saturation value; o_starved is high while count == STARVE_MAX
//
//   Ports:
//     clk        in   system clock
//     rst        in   synchronous active-high reset (clears the count)
//     i_req      in   loader request this cycle
//     i_gnt      in   loader grant this cycle
//     o_starved  out  count has reached STARVE_MAX
// -----------------------------------------------------------------------------
module imem_arb_starve_ctr
    import imem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = IMEM_STARVE_MAX
) (
    input  logic clk,
    input  logic rst,
    input  logic i_req,
    input  logic i_gnt,
    output logic o_starved
);

    localparam int unsigned      CNT_W   = starve_cnt_w(STARVE_MAX);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_max;

    assign w_at_max = (r_cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!i_req || i_gnt) begin
            r_cnt <= '0;
        end else if (!w_at_max) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_starved = w_at_max;

endmodule

// File: rtl/imem_arbiter.sv
// -----------------------------------------------------------------------------
// imem_arbiter
//   Shares the single-port instruction memory between the CPU fetch unit
//   (read-only) and the program loader / debug port (read/write). One access
//   is granted per cycle; read data returns one cycle after the grant and is
//   flagged valid towards whichever requester owned that access.
//
//   Arbitration: fetch wins contested cycles, except once the loader has been
//   denied STARVE_MAX consecutive cycles, in which case the loader wins.
//
//   Optional feature (compile-time macro IMEM_ARB_LOCK_EN):
//     Adds input load_lock. A loader grant with load_lock=1 enters LOCKED;
//     while LOCKED the fetch unit is never granted and the loader is granted
//     whenever it requests. LOCKED is left after a loader grant with
//     load_lock=0 or a cycle with load_req=0. Without the macro the port and
//     the state do not exist.
//
//   Parameters:
//     DATA_W      memory word width
//     ADDR_W      word-index address width
//     STARVE_MAX  denied loader cycles before the loader wins a contested cycle
//
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     fetch_req/fetch_addr     fetch read request and word address
//     fetch_gnt                fetch access accepted this cycle (comb)
//     fetch_valid/fetch_data   fetch read response (valid registered)
//     fetch_stall              fetch_req high but not granted
//     load_req/load_we         loader request, 1 = write
//     load_addr/load_wdata     loader word address and write data
//     load_lock                (IMEM_ARB_LOCK_EN only) request exclusive access
//     load_gnt                 loader access accepted this cycle (comb)
//     load_valid/load_rdata    loader read response (never valid for writes)
//     mem_en/mem_we            memory access / write strobe
//     mem_addr/mem_wdata       memory address and write data
//     mem_rdata                memory read data, valid the cycle after access
// -----------------------------------------------------------------------------
module imem_arbiter
    import imem_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W     = IMEM_DATA_W,
    parameter int unsigned ADDR_W     = IMEM_ADDR_W,
    parameter int unsigned STARVE_MAX = IMEM_STARVE_MAX
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_gnt,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_data,

    input  logic              load_req,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_wdata,
`ifdef IMEM_ARB_LOCK_EN
    input  logic              load_lock,
`endif
    output logic              load_gnt,
    output logic              load_valid,
    output logic [DATA_W-1:0] load_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              fetch_stall
);

    logic   w_starved;
    logic   w_fetch_gnt;
    logic   w_load_gnt;
    owner_e r_owner;

`ifdef IMEM_ARB_LOCK_EN
    owner_e r_lock_state;
    logic   w_locked;

    assign w_locked = (r_lock_state == OWN_LOCKED);
`endif

    // ------------------------------------------------------------------
    // Starvation guard for the loader
    // ------------------------------------------------------------------
    imem_arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_ctr (
        .clk       (clk),
        .rst       (rst),
        .i_req     (load_req),
        .i_gnt     (w_load_gnt),
        .o_starved (w_starved)
    );

    // ------------------------------------------------------------------
    // Grant selection; nothing is granted while rst is high
    // ------------------------------------------------------------------
    always_comb begin
        w_fetch_gnt = 1'b0;
        w_load_gnt  = 1'b0;
        if (!rst) begin
`ifdef IMEM_ARB_LOCK_EN
            if (w_locked) begin
                w_load_gnt = load_req;
            end else
`endif
            if (fetch_req && load_req) begin
                w_fetch_gnt = !w_starved;
                w_load_gnt  = w_starved;
            end else begin
                w_fetch_gnt = fetch_req;
                w_load_gnt  = load_req;
            end
        end
    end

    assign fetch_gnt   = w_fetch_gnt;
    assign load_gnt    = w_load_gnt;
    assign fetch_stall = fetch_req & ~w_fetch_gnt & ~rst;

    // ------------------------------------------------------------------
    // Memory drive from the granted requester
    // ------------------------------------------------------------------
    assign mem_en    = w_fetch_gnt | w_load_gnt;
    assign mem_we    = w_load_gnt & load_we;
    assign mem_addr  = w_load_gnt  ? load_addr  :
                       w_fetch_gnt ? fetch_addr : '0;
    assign mem_wdata = w_load_gnt  ? load_wdata : '0;

    // ------------------------------------------------------------------
    // Owner state: remembers who owns the data returning next cycle.
    // A loader write leaves the owner at NONE so no valid is raised.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner <= OWN_NONE;
`ifdef IMEM_ARB_LOCK_EN
            r_lock_state <= OWN_NONE;
`endif
        end else begin
            if (w_fetch_gnt) begin
                r_owner <= OWN_FETCH;
            end else if (w_load_gnt && !load_we) begin
                r_owner <= OWN_LOAD_RD;
            end else begin
                r_owner <= OWN_NONE;
            end
`ifdef IMEM_ARB_LOCK_EN
            // Holding the lock needs a grant with load_lock set every cycle;
            // a drop of load_req (no grant) or load_lock releases it.
            r_lock_state <= (w_load_gnt && load_lock) ? OWN_LOCKED : OWN_NONE;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Responses
    // ------------------------------------------------------------------
    assign fetch_valid = (r_owner == OWN_FETCH);
    assign load_valid  = (r_owner == OWN_LOAD_RD);
    assign fetch_data  = rst ? '0 : mem_rdata;
    assign load_rdata  = rst ? '0 : mem_rdata;

endmodule

// File: tb/tb_imem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_imem_arbiter
//   Self-checking bench for imem_arbiter. A behavioural one-cycle-latency
//   memory sits on the mem_* port; a 16-word shadow copy tracks expected
//   contents. Read expectations are queued when a grant is expected and
//   compared when the matching valid appears.
//   Build with +define+IMEM_ARB_LOCK_EN to exercise the lock feature.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_imem_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          fetch_req;
    logic [AW-1:0] fetch_addr;
    logic          fetch_gnt;
    logic          fetch_valid;
    logic [DW-1:0] fetch_data;
    logic          load_req;
    logic          load_we;
    logic [AW-1:0] load_addr;
    logic [DW-1:0] load_wdata;
`ifdef IMEM_ARB_LOCK_EN
    logic          load_lock;
`endif
    logic          load_gnt;
    logic          load_valid;
    logic [DW-1:0] load_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          fetch_stall;

    // backdoor preload port of the memory model
    logic          bd_we;
    logic [3:0]    bd_addr;
    logic [DW-1:0] bd_data;

    logic [DW-1:0] imem   [0:15];
    logic [DW-1:0] shadow [0:15];
    logic [DW-1:0] q_f [$];
    logic [DW-1:0] q_l [$];
    logic          pfv;
    logic          plv;
    int            n_tests = 0;
    int            n_fail  = 0;

    always #5 clk = ~clk;

    imem_arbiter #(
        .DATA_W     (32),
        .ADDR_W     (10),
        .STARVE_MAX (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_gnt   (fetch_gnt),
        .fetch_valid (fetch_valid),
        .fetch_data  (fetch_data),
        .load_req    (load_req),
        .load_we     (load_we),
        .load_addr   (load_addr),
        .load_wdata  (load_wdata),
`ifdef IMEM_ARB_LOCK_EN
        .load_lock   (load_lock),
`endif
        .load_gnt    (load_gnt),
        .load_valid  (load_valid),
        .load_rdata  (load_rdata),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .fetch_stall (fetch_stall)
    );

    // synchronous single-port memory, read data one cycle after access
    always @(posedge clk) begin
        if (bd_we) begin
            imem[bd_addr] <= bd_data;
        end else if (mem_en) begin
            if (mem_we) imem[mem_addr[3:0]] <= mem_wdata;
            mem_rdata <= imem[mem_addr[3:0]];
        end
    end

    task automatic set_idle();
        fetch_req  = 1'b0;
        fetch_addr = '0;
        load_req   = 1'b0;
        load_we    = 1'b0;
        load_addr  = '0;
        load_wdata = '0;
`ifdef IMEM_ARB_LOCK_EN
        load_lock  = 1'b0;
`endif
    endtask

    // -------------------------------------------------------------------
    task automatic test_reset();
        logic [DW-1:0] w;
        rst = 1'b1;
        fetch_req = 1'b1; fetch_addr = 10'd3;
        load_req = 1'b1; load_we = 1'b1; load_addr = 10'd4; load_wdata = 32'hFFFF_FFFF;
`ifdef IMEM_ARB_LOCK_EN
        load_lock = 1'b1;
`endif
        for (int i = 0; i < 16; i++) begin
            case (i)
                0:       w = 32'h0000_0013;
                1:       w = 32'h0010_0093;
                2:       w = 32'h0020_0113;
                7:       w = 32'h1234_5678;
                default: w = 32'hA5A5_0000 | 32'(i);
            endcase
            bd_we = 1'b1; bd_addr = 4'(i); bd_data = w; shadow[i] = w;
            @(negedge clk);
            if (i == 0) begin
                n_tests++;
                if ({fetch_gnt, load_gnt, mem_en, mem_we, fetch_stall} !== 5'b0) begin
                    n_fail++;
                    $display("FAIL reset_ctrl got %b exp 00000", {fetch_gnt, load_gnt, mem_en, mem_we, fetch_stall});
                end
                n_tests++;
                if (mem_addr !== '0 || mem_wdata !== '0) begin
                    n_fail++;
                    $display("FAIL reset_mem_bus got addr=%h wdata=%h exp 0/0", mem_addr, mem_wdata);
                end
                n_tests++;
                if (fetch_data !== '0 || load_rdata !== '0) begin
                    n_fail++;
                    $display("FAIL reset_data got %h/%h exp 0/0", fetch_data, load_rdata);
                end
            end
            if (i == 2) begin
                n_tests++;
                if ({fetch_valid, load_valid} !== 2'b00) begin
                    n_fail++;
                    $display("FAIL reset_valid got %b exp 00", {fetch_valid, load_valid});
                end
            end
            @(posedge clk); #1;
        end
        bd_we = 1'b0;
        rst = 1'b0;
        set_idle();
        @(negedge clk);
        n_tests++;
        if ({fetch_gnt, load_gnt, mem_en, fetch_valid, load_valid} !== 5'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle got %b exp 00000", {fetch_gnt, load_gnt, mem_en, fetch_valid, load_valid});
        end
        pfv = 1'b0; plv = 1'b0;
        @(posedge clk); #1;
    endtask

    // -------------------------------------------------------------------
    task automatic test_fetch_only();
        logic efg;
        logic [DW-1:0] ev;
        for (int c = 0; c < 5; c++) begin
            efg = (c < 3);
            set_idle();
            fetch_req = efg; fetch_addr = 10'(c);
            @(negedge clk);
            n_tests++;
            if ({fetch_gnt, load_gnt} !== {efg, 1'b0}) begin
                n_fail++;
                $display("FAIL fetch_gnt c=%0d got %b%b exp %b0", c, fetch_gnt, load_gnt, efg);
            end
            n_tests++;
            if (fetch_stall !== 1'b0 || mem_en !== efg || mem_we !== 1'b0) begin
                n_fail++;
                $display("FAIL fetch_ctrl c=%0d got stall=%b en=%b we=%b exp 0/%b/0", c, fetch_stall, mem_en, mem_we, efg);
            end
            if (efg) begin
                n_tests++;
                if (mem_addr !== fetch_addr) begin
                    n_fail++;
                    $display("FAIL fetch_mem_addr c=%0d got %h exp %h", c, mem_addr, fetch_addr);
                end
            end
            n_tests++;
            if ({fetch_valid, load_valid} !== {pfv, plv}) begin
                n_fail++;
                $display("FAIL fetch_valid c=%0d got %b%b exp %b%b", c, fetch_valid, load_valid, pfv, plv);
            end
            if (fetch_valid === 1'b1) begin
                n_tests++;
                if (q_f.size() == 0) begin
                    n_fail++;
                    $display("FAIL fetch_data c=%0d got %h exp none", c, fetch_data);
                end else begin
                    ev = q_f.pop_front();
                    if (fetch_data !== ev) begin
                        n_fail++;
                        $display("FAIL fetch_data c=%0d got %h exp %h", c, fetch_data, ev);
                    end
                end
            end
            if (efg) q_f.push_back(shadow[c]);
            pfv = efg; plv = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    // -------------------------------------------------------------------
    task automatic test_write_then_read();
        logic efg, elg;
        logic [DW-1:0] ev;
        for (int c = 0; c < 4; c++) begin
            efg = (c == 1);
            elg = (c == 0);
            set_idle();
            load_req = elg; load_we = elg; load_addr = 10'd5; load_wdata = 32'hDEAD_BEEF;
            fetch_req = efg; fetch_addr = 10'd5;
            @(negedge clk);
            n_tests++;
            if ({fetch_gnt, load_gnt} !== {efg, elg}) begin
                n_fail++;
                $display("FAIL wr_gnt c=%0d got %b%b exp %b%b", c, fetch_gnt, load_gnt, efg, elg);
            end
            n_tests++;
            if (mem_we !== elg || mem_en !== (efg | elg)) begin
                n_fail++;
                $display("FAIL wr_ctrl c=%0d got we=%b en=%b exp %b/%b", c, mem_we, mem_en, elg, efg | elg);
            end
            if (c == 0) begin
                n_tests++;
                if (mem_addr !== 10'd5 || mem_wdata !== 32'hDEAD_BEEF) begin
                    n_fail++;
                    $display("FAIL wr_bus got addr=%h wdata=%h exp 005/deadbeef", mem_addr, mem_wdata);
                end
            end
            n_tests++;
            if ({fetch_valid, load_valid} !== {pfv, plv}) begin
                n_fail++;
                $display("FAIL wr_valid c=%0d got %b%b exp %b%b", c, fetch_valid, load_valid, pfv, plv);
            end
            if (fetch_valid === 1'b1) begin
                n_tests++;
                if (q_f.size() == 0) begin
                    n_fail++;
                    $display("FAIL wr_fetch_data c=%0d got %h exp none", c, fetch_data);
                end else begin
                    ev = q_f.pop_front();
                    if (fetch_data !== ev) begin
                        n_fail++;
                        $display("FAIL wr_fetch_data c=%0d got %h exp %h", c, fetch_data, ev);
                    end
                end
            end
            if (elg) shadow[5] = 32'hDEAD_BEEF;
            if (efg) q_f.push_back(shadow[5]);
            pfv = efg; plv = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    // -------------------------------------------------------------------
    // Both requesting: fetch wins 4 cycles, loader read of addr 7 wins the
    // 5th; loader drops for a cycle, then a second round shows the counter
    // restarted from zero.
    task automatic test_starvation();
        logic efg, elg;
        logic [DW-1:0] ev;
        int unsigned nf;
        nf = 0;
        for (int c = 0; c < 12; c++) begin
            efg = (c != 4) && (c != 10) && (c != 11);
            elg = (c == 4) || (c == 10);
            set_idle();
            fetch_req = (c != 11); fetch_addr = 10'(nf);
            load_req = (c != 5) && (c != 11); load_addr = 10'd7;
            @(negedge clk);
            n_tests++;
            if ({fetch_gnt, load_gnt} !== {efg, elg}) begin
                n_fail++;
                $display("FAIL starve_gnt c=%0d got %b%b exp %b%b", c, fetch_gnt, load_gnt, efg, elg);
            end
            n_tests++;
            if (fetch_stall !== (fetch_req & ~efg) || mem_we !== 1'b0) begin
                n_fail++;
                $display("FAIL starve_stall c=%0d got stall=%b we=%b exp %b/0", c, fetch_stall, mem_we, fetch_req & ~efg);
            end
            n_tests++;
            if ({fetch_valid, load_valid} !== {pfv, plv}) begin
                n_fail++;
                $display("FAIL starve_valid c=%0d got %b%b exp %b%b", c, fetch_valid, load_valid, pfv, plv);
            end
            if (fetch_valid === 1'b1) begin
                n_tests++;
                if (q_f.size() == 0) begin
                    n_fail++;
                    $display("FAIL starve_fdata c=%0d got %h exp none", c, fetch_data);
                end else begin
                    ev = q_f.pop_front();
                    if (fetch_data !== ev) begin
                        n_fail++;
                        $display("FAIL starve_fdata c=%0d got %h exp %h", c, fetch_data, ev);
                    end
                end
            end
            if (load_valid === 1'b1) begin
                n_tests++;
                if (q_l.size() == 0) begin
                    n_fail++;
                    $display("FAIL starve_ldata c=%0d got %h exp none", c, load_rdata);
                end else begin
                    ev = q_l.pop_front();
                    if (load_rdata !== ev) begin
                        n_fail++;
                        $display("FAIL starve_ldata c=%0d got %h exp %h", c, load_rdata, ev);
                    end
                end
            end
            if (efg) begin
                q_f.push_back(shadow[fetch_addr[3:0]]);
                nf++;
            end
            if (elg) q_l.push_back(shadow[7]);
            pfv = efg; plv = elg;
            @(posedge clk); #1;
        end
    endtask

    // -------------------------------------------------------------------
    // Contention for three cycles, reset in the cycle after the last fetch
    // grant, then contention again: a cleared starve count gives four fetch
    // grants before the loader wins.
    task automatic test_reset_mid();
        logic efg, elg;
        logic [DW-1:0] ev;
        int unsigned nf;
        nf = 0;
        for (int c = 0; c < 10; c++) begin
            efg = (c < 3) || (c >= 4 && c <= 7);
            elg = (c == 8);
            set_idle();
            rst = (c == 3);
            fetch_req = (c != 9); fetch_addr = 10'(nf);
            load_req = (c != 9); load_addr = 10'd7;
            @(negedge clk);
            n_tests++;
            if ({fetch_gnt, load_gnt} !== {efg, elg}) begin
                n_fail++;
                $display("FAIL rstmid_gnt c=%0d got %b%b exp %b%b", c, fetch_gnt, load_gnt, efg, elg);
            end
            n_tests++;
            if (fetch_stall !== (fetch_req & ~efg & ~rst) || mem_en !== (efg | elg)) begin
                n_fail++;
                $display("FAIL rstmid_ctrl c=%0d got stall=%b en=%b exp %b/%b", c, fetch_stall, mem_en, fetch_req & ~efg & ~rst, efg | elg);
            end
            if (c != 3) begin
                n_tests++;
                if ({fetch_valid, load_valid} !== {pfv, plv}) begin
                    n_fail++;
                    $display("FAIL rstmid_valid c=%0d got %b%b exp %b%b", c, fetch_valid, load_valid, pfv, plv);
                end
                if (fetch_valid === 1'b1) begin
                    n_tests++;
                    if (q_f.size() == 0) begin
                        n_fail++;
                        $display("FAIL rstmid_fdata c=%0d got %h exp none", c, fetch_data);
                    end else begin
                        ev = q_f.pop_front();
                        if (fetch_data !== ev) begin
                            n_fail++;
                            $display("FAIL rstmid_fdata c=%0d got %h exp %h", c, fetch_data, ev);
                        end
                    end
                end
                if (load_valid === 1'b1) begin
                    n_tests++;
                    if (q_l.size() == 0) begin
                        n_fail++;
                        $display("FAIL rstmid_ldata c=%0d got %h exp none", c, load_rdata);
                    end else begin
                        ev = q_l.pop_front();
                        if (load_rdata !== ev) begin
                            n_fail++;
                            $display("FAIL rstmid_ldata c=%0d got %h exp %h", c, load_rdata, ev);
                        end
                    end
                end
            end else begin
                // the access granted just before reset is abandoned
                q_f.delete();
                q_l.delete();
            end
            if (efg) begin
                q_f.push_back(shadow[fetch_addr[3:0]]);
                nf++;
            end
            if (elg) q_l.push_back(shadow[7]);
            pfv = efg; plv = elg;
            @(posedge clk); #1;
        end
        rst = 1'b0;
    endtask

`ifdef IMEM_ARB_LOCK_EN
    // -------------------------------------------------------------------
    // Locked download: one locking write with fetch idle, three locking
    // writes with fetch requesting, one write that releases the lock, then
    // fetch reads back two of the written words.
    task automatic test_lock();
        logic efg, elg;
        logic [DW-1:0] ev;
        for (int c = 0; c < 8; c++) begin
            elg = (c <= 4);
            efg = (c == 5) || (c == 6);
            set_idle();
            load_req   = elg;
            load_we    = 1'b1;
            load_addr  = 10'(8 + c);
            load_wdata = 32'hC0DE_0000 + 32'(c);
            load_lock  = (c <= 3);
            fetch_req  = (c >= 1) && (c <= 6);
            fetch_addr = (c == 6) ? 10'd12 : 10'd9;
            @(negedge clk);
            n_tests++;
            if ({fetch_gnt, load_gnt} !== {efg, elg}) begin
                n_fail++;
                $display("FAIL lock_gnt c=%0d got %b%b exp %b%b", c, fetch_gnt, load_gnt, efg, elg);
            end
            n_tests++;
            if (fetch_stall !== (fetch_req & ~efg) || mem_we !== elg) begin
                n_fail++;
                $display("FAIL lock_ctrl c=%0d got stall=%b we=%b exp %b/%b", c, fetch_stall, mem_we, fetch_req & ~efg, elg);
            end
            n_tests++;
            if ({fetch_valid, load_valid} !== {pfv, plv}) begin
                n_fail++;
                $display("FAIL lock_valid c=%0d got %b%b exp %b%b", c, fetch_valid, load_valid, pfv, plv);
            end
            if (fetch_valid === 1'b1) begin
                n_tests++;
                if (q_f.size() == 0) begin
                    n_fail++;
                    $display("FAIL lock_fdata c=%0d got %h exp none", c, fetch_data);
                end else begin
                    ev = q_f.pop_front();
                    if (fetch_data !== ev) begin
                        n_fail++;
                        $display("FAIL lock_fdata c=%0d got %h exp %h", c, fetch_data, ev);
                    end
                end
            end
            if (elg) shadow[8 + c] = load_wdata;
            if (efg) q_f.push_back(shadow[fetch_addr[3:0]]);
            pfv = efg; plv = 1'b0;
            @(posedge clk); #1;
        end
    endtask
`endif

    // -------------------------------------------------------------------
    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        pfv   = 1'b0; plv = 1'b0;
        set_idle();
        @(posedge clk); #1;
        test_reset();
        test_fetch_only();
        test_write_then_read();
        test_starvation();
        test_reset_mid();
`ifdef IMEM_ARB_LOCK_EN
        test_lock();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
